master_byte_engine: RTL and testbench
=====================================

// Module: master_byte_engine
// PURPOSE
//  Master-side bit engine for the I2C link: moves one byte plus its ACK bit per request.
//  Write: shifts tx_data out MSB-first, releases SDA in bit 9, samples the slave acknowledge.
//  Read: releases SDA for 8 bits and samples slave data, then drives master ACK/NACK in bit 9.
//  Sits between the master control FSM (START/STOP generation lives there) and the SDA/SCL pads.
// PARAMETERS
//  CLK_DIV   4   clk cycles per SCL quarter-period (>=2); one bit = 4*CLK_DIV clk
// PORTS
//  clk           in   1  single system clock; all logic on posedge
//  rst           in   1  synchronous, active-high reset
//  start         in   1  request one byte transfer; accepted only when busy=0
//  rw            in   1  captured with start: 0 = write, 1 = read
//  tx_data       in   8  byte to send (captured with start, write only)
//  send_nack     in   1  captured with start (read only): 1 = NACK in bit 9, 0 = ACK
//  sda_in        in   1  sampled SDA line
//  scl_in        in   1  sampled SCL line (clock-stretch detect)
//  scl_out       out  1  1 = release SCL, 0 = pull low
//  sda_oe        out  1  1 = pull SDA low; 0 = release (open-drain)
//  busy          out  1  transfer in progress
//  done          out  1  one-cycle pulse at end of bit 9
//  rx_data       out  8  received byte, valid from done (read)
//  ack_ok        out  1  write: 1 = slave drove SDA low in bit 9; valid from done
// BEHAVIOUR
//  - Reset: scl_out=1, sda_oe=0, busy=0, done=0, rx_data=0, ack_ok=0, state IDLE, counters 0.
//  - States: IDLE -> BIT (bits 7..0) -> ACK (bit 9) -> DONE (1 cycle) -> IDLE.
//  - start with busy=0: capture rw/tx_data/send_nack; busy=1 next cycle, SCL phase Q0 begins.
//  - start while busy=1: ignored, captured values unchanged.
//  - Each bit = quarters Q0..Q3, CLK_DIV clk each:
//    Q0: scl_out=0; first clk of Q0 updates sda_oe. Q1: scl_out=0.
//    Q2: scl_out=1; sample sda_in on last clk of Q2. Q3: scl_out=1.
//  - Write data bit: sda_oe = ~bit; read data bit: sda_oe=0; sample shifts into rx_data LSB.
//  - Bit 9 write: sda_oe=0, ack_ok <= ~sda_in at Q2 sample. Read: sda_oe = ~send_nack.
//  - Clock stretching: in Q2, quarter counter holds while scl_in=0; resumes when scl_in=1.
//    Stretch only extends Q2; no other phase checks scl_in.
//  - Latency with no stretch: done asserts exactly 36*CLK_DIV+1 clk after the start cycle.
//  - DONE: done=1 one cycle, busy=0 same cycle; scl_out stays 0 (bus held low for next byte
//    or STOP from master FSM); sda_oe=0. start may be accepted in the cycle after done.
//  - Bit counter 4 bits, counts 8 down to 0, 0 = ACK bit; no wrap past 0.
//  - rx_data updates only on read transfers; ack_ok only on write transfers.
//  - rst mid-transfer: all outputs to reset values next edge, transfer discarded, no done.
// STRUCTURE
//  - Package i2c_master_pkg: state encoding (IDLE, BIT, ACK, DONE), BITS_PER_BYTE=8,
//    I2C_ACK=1'b0, I2C_NACK=1'b1, quarter encoding Q0..Q3.
//  - Sub-module i2c_quarter_tick: CLK_DIV counter with hold input (stretch); emits
//    quarter-end tick and 2-bit quarter index. Engine FSM, shift register, bit counter in top.
// TESTING (CLK_DIV=4)
//  - Write 8'hA5, slave ACK -> sda_oe per bit 0,1,0,1,1,0,1,0; bit 9 released;
//    ack_ok=1; done exactly 145 clk after start.
//  - Write 8'h00, slave leaves SDA high in bit 9 -> ack_ok=0, done still at 145 clk.
//  - Read, slave drives 8'h3C, send_nack=1 -> rx_data=8'h3C at done; sda_oe=0 all 9 bits.
//    Repeat with send_nack=0 -> sda_oe=1 throughout bit 9.
//  - Stretch: hold scl_in=0 for 10 clk in Q2 of bit 3 -> done delayed to 155 clk; data intact.
//  - start pulsed while busy -> ignored, first byte's pattern unchanged, one done only.
//  - rst asserted in bit 5 -> next edge scl_out=1, sda_oe=0, busy=0; no done pulse;
//    new start afterwards completes normally.

Source files
------------

// File: rtl/i2c_master_pkg.sv
// i2c_master_pkg: shared encodings and constants for the I2C master byte engine
package i2c_master_pkg;
    typedef enum logic [1:0] {IDLE, BIT, ACK, DONE} state_t;
    typedef enum logic [1:0] {Q0, Q1, Q2, Q3} quarter_t;
    localparam int BITS_PER_BYTE = 8;
    localparam logic I2C_ACK = 1'b0;
    localparam logic I2C_NACK = 1'b1;
endpackage

// File: rtl/master_byte_engine_if.sv
// master_byte_engine_if: request/response and pad signals of the byte engine
interface master_byte_engine_if;
    logic start;
    logic rw;
    logic [7:0] tx_data;
    logic send_nack;
    logic sda_in;
    logic scl_in;
    logic scl_out;
    logic sda_oe;
    logic busy;
    logic done;
    logic [7:0] rx_data;
    logic ack_ok;
    modport master (
        output start, rw, tx_data, send_nack, sda_in, scl_in,
        input scl_out, sda_oe, busy, done, rx_data, ack_ok
    );
    modport slave (
        input start, rw, tx_data, send_nack, sda_in, scl_in,
        output scl_out, sda_oe, busy, done, rx_data, ack_ok
    );
endinterface

// File: rtl/i2c_quarter_tick.sv
// i2c_quarter_tick: divides clk into SCL quarter periods, freezing while held
module i2c_quarter_tick
    import i2c_master_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input logic clk,
    input logic rst,
    input logic run,
    input logic hold,
    output logic tick,
    output quarter_t quarter
);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    logic [CW-1:0] cnt;
    assign tick = run && !hold && cnt == CW'(CLK_DIV - 1);
    // count clk within a quarter and advance the quarter index on its last clk
    always_ff @(posedge clk) begin
        if (rst || !run) begin
            cnt <= '0;
            quarter <= Q0;
        end else if (!hold) begin
            cnt <= tick ? '0 : cnt + 1'b1;
            if (tick)
                quarter <= quarter_t'(2'(quarter + 2'd1));
        end
    end
endmodule

// File: rtl/master_byte_engine.sv
// master_byte_engine: moves one byte plus ACK bit over SDA/SCL per request
module master_byte_engine
    import i2c_master_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input logic clk,
    input logic rst,
    master_byte_engine_if.slave bus
);
    state_t state, state_n;
    quarter_t quarter;
    logic tick, run, hold, last, sample;
    logic rw_q, nack_q, ack_q, scl_idle;
    logic [3:0] bit_cnt;
    logic [7:0] tx_q, rx_q;

    assign run = state == BIT || state == ACK;
    assign hold = quarter == Q2 && !bus.scl_in;
    assign last = tick && quarter == Q3;
    assign sample = tick && quarter == Q2;

    i2c_quarter_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk(clk),
        .rst(rst),
        .run(run),
        .hold(hold),
        .tick(tick),
        .quarter(quarter)
    );

    // sequence IDLE -> 8 data bits -> ACK bit -> one DONE cycle
    always_comb begin
        state_n = state;
        case (state)
            IDLE: state_n = bus.start ? BIT : IDLE;
            BIT: state_n = (last && bit_cnt == 4'd1) ? ACK : BIT;
            ACK: state_n = last ? DONE : ACK;
            default: state_n = IDLE;
        endcase
    end

    // state register, request capture, bit counting and SDA sampling
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            rw_q <= 1'b0;
            nack_q <= 1'b0;
            ack_q <= 1'b0;
            scl_idle <= 1'b1;
            bit_cnt <= 4'd0;
            tx_q <= 8'd0;
            rx_q <= 8'd0;
        end else begin
            state <= state_n;
            if (state == IDLE && bus.start) begin
                rw_q <= bus.rw;
                nack_q <= bus.send_nack;
                tx_q <= bus.tx_data;
                bit_cnt <= 4'(BITS_PER_BYTE);
                scl_idle <= 1'b0;
            end else if (last && bit_cnt != 4'd0) begin
                bit_cnt <= bit_cnt - 4'd1;
                tx_q <= {tx_q[6:0], 1'b0};
            end
            if (sample && state == BIT && rw_q)
                rx_q <= {rx_q[6:0], bus.sda_in};
            if (sample && state == ACK && !rw_q)
                ack_q <= bus.sda_in == I2C_ACK;
        end
    end

    // SCL stays low once a transfer has run; only reset releases it while idle
    assign bus.scl_out = run ? (quarter == Q2 || quarter == Q3) : (state == IDLE && scl_idle);
    assign bus.sda_oe = state == BIT ? (!rw_q && !tx_q[7]) : (state == ACK && rw_q && nack_q == I2C_ACK);
    assign bus.busy = run;
    assign bus.done = state == DONE;
    assign bus.rx_data = rx_q;
    assign bus.ack_ok = ack_q;
endmodule

// File: tb/tb_master_byte_engine.sv
// tb_master_byte_engine: randomized scoreboard bench with an I2C slave model
module tb_master_byte_engine;
    localparam int D = 4;
    localparam int LAT = 36 * D + 1;

    typedef struct {
        logic [7:0] rx;
        logic ack;
        logic [8:0] pat;
        int due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;
    exp_t q[$];
    logic [7:0] m_rx = 8'd0;
    logic m_ack = 1'b0;

    logic cur_rw = 1'b0;
    logic [7:0] slave_byte = 8'd0;
    logic slave_ack = 1'b1;
    logic slave_sda;
    int slave_k = 0;
    int stretch_k = -1;
    int st_cnt = 0;
    logic st_prev = 1'b1;
    logic stretch = 1'b0;

    master_byte_engine_if bus();

    master_byte_engine #(.CLK_DIV(D)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign bus.scl_in = bus.scl_out & ~stretch;
    assign bus.sda_in = ~bus.sda_oe & slave_sda;

    always_comb slave_sda = slave_k < 8 ? (!cur_rw || slave_byte[3'(7 - slave_k)]) : (cur_rw || !slave_ack);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // slave bit index advances on each falling SCL inside a transfer
    logic s_prev_scl = 1'b1;
    logic s_prev_busy = 1'b0;
    always @(negedge clk) begin
        if (rst)
            slave_k = 0;
        else if (bus.busy && !s_prev_busy)
            slave_k = 0;
        else if (bus.busy && s_prev_scl && !bus.scl_out)
            slave_k++;
        s_prev_scl = bus.scl_out;
        s_prev_busy = bus.busy;
    end

    // slave stretches SCL for 10 clk at the rising edge of the chosen bit
    always @(negedge clk) begin
        if (st_cnt > 0)
            st_cnt--;
        else if (bus.busy && bus.scl_out && !st_prev && slave_k == stretch_k)
            st_cnt = 10;
        st_prev = bus.scl_out;
        stretch = st_cnt > 0;
    end

    // monitor: record SDA drive per SCL high phase and score each done pulse
    logic m_prev_busy = 1'b0;
    logic m_prev_scl = 1'b1;
    logic m_prev_oe = 1'b0;
    logic [8:0] pat = 9'd0;
    int pat_n = 0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (bus.busy && !m_prev_busy) begin
                pat = 9'd0;
                pat_n = 0;
            end
            if (bus.busy && bus.scl_out && !m_prev_scl) begin
                pat = {pat[7:0], bus.sda_oe};
                pat_n++;
            end
            if (bus.busy && bus.scl_out && m_prev_scl)
                chk("sda_stable_scl_high", 32'(bus.sda_oe), 32'(m_prev_oe));
            if (bus.done) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 32'(bus.done), 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("done_cycle", cyc, e.due);
                    chk("sda_pattern", 32'(pat), 32'(e.pat));
                    chk("bit_count", pat_n, 9);
                    chk("rx_data", 32'(bus.rx_data), 32'(e.rx));
                    chk("ack_ok", 32'(bus.ack_ok), 32'(e.ack));
                    chk("done_scl_low", 32'(bus.scl_out), 32'd0);
                    chk("done_sda_rel", 32'(bus.sda_oe), 32'd0);
                    chk("done_busy", 32'(bus.busy), 32'd0);
                end
            end
        end
        m_prev_busy = bus.busy;
        m_prev_scl = bus.scl_out;
        m_prev_oe = bus.sda_oe;
    end

    task automatic issue(input logic rw, input logic [7:0] data, input logic nack,
                         input logic [7:0] sb, input logic sack, input int sk);
        exp_t e;
        @(negedge clk);
        cur_rw = rw;
        slave_byte = sb;
        slave_ack = sack;
        stretch_k = sk;
        if (rw) begin
            m_rx = sb;
            e.pat = {8'h00, ~nack};
        end else begin
            m_ack = sack;
            e.pat = {~data, 1'b0};
        end
        e.rx = m_rx;
        e.ack = m_ack;
        e.due = cyc + LAT + (sk >= 0 ? 10 : 0);
        q.push_back(e);
        bus.start = 1'b1;
        bus.rw = rw;
        bus.tx_data = data;
        bus.send_nack = nack;
        @(negedge clk);
        bus.start = 1'b0;
        bus.rw = 1'($urandom);
        bus.tx_data = 8'($urandom);
        bus.send_nack = 1'($urandom);
    endtask

    task automatic wait_empty();
        for (int i = 0; i < 3000 && q.size() > 0; i++)
            @(negedge clk);
        chk("drain_timeout", q.size(), 0);
        q.delete();
        @(negedge clk);
    endtask

    task automatic xfer(input logic rw, input logic [7:0] data, input logic nack,
                        input logic [7:0] sb, input logic sack, input int sk);
        issue(rw, data, nack, sb, sack, sk);
        wait_empty();
    endtask

    initial begin
        bus.start = 1'b0;
        bus.rw = 1'b0;
        bus.tx_data = 8'd0;
        bus.send_nack = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_scl_out", 32'(bus.scl_out), 32'd1);
        chk("rst_sda_oe", 32'(bus.sda_oe), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_rx_data", 32'(bus.rx_data), 32'd0);
        chk("rst_ack_ok", 32'(bus.ack_ok), 32'd0);
        rst = 1'b0;
        xfer(1'b0, 8'hA5, 1'b0, 8'h00, 1'b1, -1);
        xfer(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, -1);
        xfer(1'b1, 8'h00, 1'b1, 8'h3C, 1'b0, -1);
        xfer(1'b1, 8'h00, 1'b0, 8'h3C, 1'b0, -1);
        xfer(1'b0, 8'h5A, 1'b0, 8'h00, 1'b1, 4);
        issue(1'b0, 8'hA5, 1'b0, 8'h00, 1'b1, -1);
        repeat (40) @(negedge clk);
        bus.start = 1'b1;
        bus.rw = 1'b1;
        bus.tx_data = 8'hFF;
        bus.send_nack = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        wait_empty();
        issue(1'b0, 8'hC3, 1'b0, 8'h00, 1'b1, -1);
        for (int i = 0; i < 500 && slave_k != 2; i++)
            @(negedge clk);
        chk("reach_bit5", slave_k, 2);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_scl_out", 32'(bus.scl_out), 32'd1);
        chk("midrst_sda_oe", 32'(bus.sda_oe), 32'd0);
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_done", 32'(bus.done), 32'd0);
        chk("midrst_ack_ok", 32'(bus.ack_ok), 32'd0);
        rst = 1'b0;
        q.delete();
        m_rx = 8'd0;
        m_ack = 1'b0;
        repeat (200) @(negedge clk);
        xfer(1'b1, 8'h00, 1'b0, 8'h96, 1'b0, -1);
        for (int i = 0; i < 12; i++)
            xfer(1'($urandom), 8'($urandom), 1'($urandom), 8'($urandom), 1'($urandom),
                 ($urandom % 3 == 0) ? int'($urandom % 9) : -1);
        repeat (200) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
